// File: rtl/pwm_1000x_core.sv
// pwm_1000x_core
//   PWM generator behind the myip_PWM_1000x AXI4-Lite register bank.
//   The cfg_* values are copied into shadow registers either when the core
//   leaves IDLE or at a period boundary after a cfg_load. Only the shadow
//   copies drive the waveform, so a period is never torn by a register write.
//
// Ports
//   s00_axi_aclk     clock
//   s00_axi_aresetn  asynchronous active-low reset
//   cfg_enable       run request
//   cfg_invert       output polarity (applied through the shadow copy)
//   cfg_div          clocks per step minus one
//   cfg_duty         high steps per period (saturates at STEPS)
//   cfg_load         pulse: slv_reg1/slv_reg2 written
//   pwm_out          registered PWM level
//   period_tick      one-cycle pulse marking the last clock of a period
//   step_cnt         step index that goes with the current pwm_out value
//   busy             core is in RUN or STOPPING
//   load_pending     new configuration captured, not yet applied
module pwm_1000x_core #(
  parameter int STEPS  = 1000,
  parameter int STEP_W = 10,
  parameter int DIV_W  = 32
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  input  logic              cfg_enable,
  input  logic              cfg_invert,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [31:0]       cfg_duty,
  input  logic              cfg_load,
  output logic              pwm_out,
  output logic              period_tick,
  output logic [STEP_W-1:0] step_cnt,
  output logic              busy,
  output logic              load_pending
);

  // Wide enough to hold STEPS itself (duty == STEPS means always high).
  localparam int DUTY_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   presc_reg, presc_next;
  logic [STEP_W-1:0]  step_reg, step_next;
  logic [DIV_W-1:0]   div_sh_reg, div_sh_next;
  logic [DUTY_W-1:0]  duty_sh_reg, duty_sh_next;
  logic               inv_sh_reg, inv_sh_next;
  logic               pend_reg, pend_next;

  logic               pwm_out_reg, pwm_out_next;
  logic               period_tick_reg, period_tick_next;
  logic [STEP_W-1:0]  step_cnt_reg, step_cnt_next;
  logic               busy_reg, busy_next;

  logic               active;
  logic               presc_last;
  logic               step_last;
  logic               boundary;
  logic               raw_level;
  logic [DUTY_W-1:0]  duty_sat;

  assign duty_sat   = (cfg_duty > 32'(STEPS)) ? DUTY_W'(STEPS) : cfg_duty[DUTY_W-1:0];
  assign active     = (state_reg != IDLE);
  assign presc_last = (presc_reg == div_sh_reg);
  assign step_last  = (step_reg == STEP_W'(STEPS - 1));
  assign boundary   = active && presc_last && step_last;
  // Compare at 32 bits so STEP_W and DUTY_W may differ without truncation.
  assign raw_level  = (32'(step_reg) < 32'(duty_sh_reg));

  always_comb begin
    state_next   = state_reg;
    presc_next   = presc_reg;
    step_next    = step_reg;
    div_sh_next  = div_sh_reg;
    duty_sh_next = duty_sh_reg;
    inv_sh_next  = inv_sh_reg;
    pend_next    = pend_reg;

    case (state_reg)
      IDLE: begin
        presc_next = '0;
        step_next  = '0;
        if (cfg_enable) begin
          state_next   = RUN;
          div_sh_next  = cfg_div;
          duty_sh_next = duty_sat;
          inv_sh_next  = cfg_invert;
          pend_next    = 1'b0;
        end else if (cfg_load) begin
          pend_next = 1'b1;
        end
      end

      default: begin
        // Prescaler / step counters
        if (presc_last) begin
          presc_next = '0;
          step_next  = step_last ? '0 : step_reg + STEP_W'(1);
        end else begin
          presc_next = presc_reg + DIV_W'(1);
        end

        // Shadow update only at the period boundary; cfg values are sampled
        // here, so the last write before the boundary wins.
        if (boundary && (pend_reg || cfg_load)) begin
          div_sh_next  = cfg_div;
          duty_sh_next = duty_sat;
          inv_sh_next  = cfg_invert;
          pend_next    = 1'b0;
        end else if (cfg_load) begin
          pend_next = 1'b1;
        end

        // A disable that lands exactly on a boundary stops right away
        // instead of running one more full period.
        if (state_reg == RUN) begin
          if (!cfg_enable) begin
            state_next = boundary ? IDLE : STOPPING;
          end
        end else begin
          if (cfg_enable) begin
            state_next = RUN;
          end else if (boundary) begin
            state_next = IDLE;
          end
        end

        if (state_next == IDLE) begin
          presc_next = '0;
          step_next  = '0;
        end
      end
    endcase
  end

  // Output stage: one clock behind the counters.
  always_comb begin
    pwm_out_next     = active ? (raw_level ^ inv_sh_reg) : inv_sh_reg;
    period_tick_next = boundary;
    step_cnt_next    = step_reg;
    busy_next        = (state_next != IDLE);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_reg       <= IDLE;
      presc_reg       <= '0;
      step_reg        <= '0;
      div_sh_reg      <= '0;
      duty_sh_reg     <= '0;
      inv_sh_reg      <= 1'b0;
      pend_reg        <= 1'b0;
      pwm_out_reg     <= 1'b0;
      period_tick_reg <= 1'b0;
      step_cnt_reg    <= '0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      presc_reg       <= presc_next;
      step_reg        <= step_next;
      div_sh_reg      <= div_sh_next;
      duty_sh_reg     <= duty_sh_next;
      inv_sh_reg      <= inv_sh_next;
      pend_reg        <= pend_next;
      pwm_out_reg     <= pwm_out_next;
      period_tick_reg <= period_tick_next;
      step_cnt_reg    <= step_cnt_next;
      busy_reg        <= busy_next;
    end
  end

  assign pwm_out      = pwm_out_reg;
  assign period_tick  = period_tick_reg;
  assign step_cnt     = step_cnt_reg;
  assign busy         = busy_reg;
  assign load_pending = pend_reg;

endmodule

// File: doc/pwm_1000x_core.md
# pwm_1000x_core

PWM generation core driven by the AXI4-Lite register file of the myip_PWM_1000x peripheral. Consumes the control, divider and duty values written over S00_AXI, double-buffers them, and produces a 1000-step-resolution PWM waveform with period-boundary-synchronous updates. Sits directly downstream of the slave register bank; its status outputs are read back through the same register map.

## Interface
- STEPS, 1000, steps per PWM period (duty resolution)
- STEP_W, 10, width of step counter (ceil(log2(STEPS)))
- DIV_W, 32, width of prescaler divider
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset; asynchronous, active-low
- cfg_enable  in  1  run request (slv_reg0[0])
- cfg_invert  in  1  output polarity invert (slv_reg0[1])
- cfg_div  in  DIV_W  clocks per step minus 1 (slv_reg1)
- cfg_duty  in  32  high steps per period (slv_reg2)
- cfg_load  in  1  one-cycle pulse on any write to slv_reg1/slv_reg2
- pwm_out  out  1  registered PWM output
- period_tick  out  1  one-cycle pulse on the last clock of each period
- step_cnt  out  STEP_W  current step index (status, slv_reg3[9:0])
- busy  out  1  high in RUN or STOPPING (slv_reg3[16])
- load_pending  out  1  new config captured, not yet applied (slv_reg3[17])

## Operation
- Shadow registers div_sh, duty_sh, inv_sh; only shadows drive the waveform.
- duty_sh = min(cfg_duty, STEPS); wider values saturate.
- States: IDLE, RUN, STOPPING.
- IDLE: prescaler=0, step=0, pwm_out=inv_sh. cfg_enable=1 -> RUN; shadows loaded from cfg_* on that transition; load_pending cleared.
- RUN: prescaler counts 0..div_sh; on prescaler==div_sh it wraps to 0 and step increments; step wraps STEPS-1 -> 0.
- Period boundary = prescaler==div_sh and step==STEPS-1: period_tick=1; if load_pending or cfg_load this cycle, shadows take cfg_* values, load_pending cleared.
- cfg_load outside a boundary cycle sets load_pending; multiple loads before a boundary: last cfg values win (sampled at boundary).
- cfg_invert is applied only via shadow at boundary or IDLE exit.
- RUN with cfg_enable=0 -> STOPPING; waveform continues unchanged.
- STOPPING: cfg_enable=1 -> RUN with no interruption of counters; boundary reached -> IDLE (period_tick still issued, pending load applied).
- Raw level = (step < duty_sh); pwm_out = raw XOR inv_sh; duty_sh=0 -> constant low, duty_sh=STEPS -> constant high (before invert).
- busy = (state != IDLE).
- Reset (any time, incl. mid-period): state=IDLE, all counters/shadows 0, pwm_out=0, period_tick=0, step_cnt=0, busy=0, load_pending=0.

## Timing
- pwm_out, period_tick, step_cnt, busy, load_pending all registered.
- pwm_out reflects counter state of the previous cycle: one-clock latency.
- Enable to first step: cfg_enable sampled high at edge N -> state RUN, step 0 active from N+1; pwm_out valid for step 0 at N+2.
- Period length = STEPS*(div_sh+1) clocks; high time = duty_sh*(div_sh+1) clocks.
- div_sh=0: step advances every clock, period 1000 clocks.
- period_tick asserted exactly one clock per period, coincident with last step’s final prescaler cycle (output one cycle later due to register).
- New config visible at first step of period following boundary.
- STOPPING -> IDLE in boundary cycle; pwm_out = inv_sh from next clock.

## Test plan
- Reset, cfg_div=0, cfg_duty=250, cfg_enable=1 -> pwm_out high 250 clocks, low 750, period_tick every 1000 clocks, busy=1.
- cfg_div=3, cfg_duty=500 -> period 4000 clocks, high 2000; step_cnt increments every 4 clocks.
- Running duty=100, cfg_duty=600 + cfg_load at step 300 -> load_pending=1, current period high 100 steps, next period 600, load_pending=0 after boundary.
- cfg_duty=0 -> pwm_out constant 0; cfg_duty=1200 -> constant 1; cfg_invert=1 with duty=250 -> low 250, high 750 after boundary.
- cfg_enable=0 at step 300 -> steps continue to 999, one period_tick, then IDLE, busy=0, pwm_out=0; re-enable at step 800 in STOPPING -> no gap, RUN continues.
- s00_axi_aresetn low at step 500 mid-high -> all outputs 0 asynchronously; release with enable=1 -> restarts at step 0.
